// File: rtl/pulp_clock_mux2_ctrl.sv
// Switch sequencer for a 2:1 clock mux and its downstream clock gate.
// Gates the clock, drains, flips the mux select, settles, then re-enables.
//
// Ports:
//   clk_i        free-running reference clock
//   rst_i        synchronous reset, active-high
//   req_valid_i  switch request valid
//   req_sel_i    requested mux select (0: clk0, 1: clk1)
//   req_ready_o  request can be accepted (controller idle)
//   done_o       one-cycle pulse when a request completes
//   busy_o       switch sequence in progress
//   clk_sel_o    select to mux S input
//   clk_en_o     enable to downstream clock gate
//   cur_sel_o    select currently in effect
//   sw_count_o   saturating count of completed real switches
module pulp_clock_mux2_ctrl #(
    parameter logic        RESET_SEL     = 1'b0,
    parameter int unsigned DRAIN_CYCLES  = 4,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    input  logic             req_sel_i,
    output logic             req_ready_o,
    output logic             done_o,
    output logic             busy_o,
    output logic             clk_sel_o,
    output logic             clk_en_o,
    output logic             cur_sel_o,
    output logic [CNT_W-1:0] sw_count_o
);

    localparam int unsigned MAX_CYC =
        (DRAIN_CYCLES > SETTLE_CYCLES) ? DRAIN_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CW = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] DRAIN_LOAD  = CW'(DRAIN_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        SETTLE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             sel_q, sel_d;
    logic             en_q, en_d;
    logic             cur_q, cur_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;

    logic accept;
    logic same_sel;
    logic cnt_zero;

    // ready_q mirrors (state_q == IDLE), so it doubles as the idle flag
    assign accept   = req_valid_i && ready_q;
    assign same_sel = (req_sel_i == cur_q);
    assign cnt_zero = (cnt_q == '0);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pend_q   <= RESET_SEL;
            sel_q    <= RESET_SEL;
            en_q     <= 1'b1;
            cur_q    <= RESET_SEL;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            sw_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            sel_q    <= sel_d;
            en_q     <= en_d;
            cur_q    <= cur_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            sw_cnt_q <= sw_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept && !same_sel) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_zero) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values; every output is registered
    always_comb begin
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        sel_d    = sel_q;
        en_d     = en_q;
        cur_d    = cur_q;
        done_d   = 1'b0;
        sw_cnt_d = sw_cnt_q;
        ready_d  = (state_d == IDLE);

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    pend_d = req_sel_i;
                    if (same_sel) begin
                        // Already on the requested clock: no gating
                        done_d = 1'b1;
                    end else begin
                        en_d  = 1'b0;
                        cnt_d = DRAIN_LOAD;
                    end
                end
            end
            DRAIN: begin
                if (cnt_zero) begin
                    // Gate has been closed long enough; flip the mux
                    sel_d = pend_q;
                    cnt_d = SETTLE_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_zero) begin
                    en_d   = 1'b1;
                    cur_d  = pend_q;
                    done_d = 1'b1;
                    if (sw_cnt_q != '1) begin
                        sw_cnt_d = sw_cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign req_ready_o = ready_q;
    assign busy_o      = ~ready_q;
    assign done_o      = done_q;
    assign clk_sel_o   = sel_q;
    assign clk_en_o    = en_q;
    assign cur_sel_o   = cur_q;
    assign sw_count_o  = sw_cnt_q;

endmodule

// File: tb/tb_pulp_clock_mux2_ctrl.sv
// Testbench for pulp_clock_mux2_ctrl: directed timing checks plus
// randomized traffic compared every cycle against an event-time model.
module tb_pulp_clock_mux2_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic v1 = 1'b0, s1 = 1'b0;
    logic v2 = 1'b0, s2 = 1'b0;

    logic r1, d1, b1, cs1, ce1, cu1;
    logic [7:0] n1;
    logic r2, d2, b2, cs2, ce2, cu2;
    logic [1:0] n2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pulp_clock_mux2_ctrl dut1 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(v1), .req_sel_i(s1),
        .req_ready_o(r1), .done_o(d1), .busy_o(b1),
        .clk_sel_o(cs1), .clk_en_o(ce1), .cur_sel_o(cu1),
        .sw_count_o(n1)
    );

    pulp_clock_mux2_ctrl #(
        .RESET_SEL(1'b1), .DRAIN_CYCLES(1),
        .SETTLE_CYCLES(1), .CNT_W(2)
    ) dut2 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(v2), .req_sel_i(s2),
        .req_ready_o(r2), .done_o(d2), .busy_o(b2),
        .clk_sel_o(cs2), .clk_en_o(ce2), .cur_sel_o(cu2),
        .sw_count_o(n2)
    );

    // Model: a switch accepted at edge e flips the select at edge e+D
    // and finishes at edge e+D+S; outputs reflect the state after an edge.
    typedef struct {
        bit busy;
        bit sel;
        bit en;
        bit cur;
        bit done;
        bit pend;
        int sel_e;
        int end_e;
        int unsigned cnt;
    } m_t;

    m_t m1, m2;
    int edge_n = 0;
    bit live = 0;

    function automatic m_t step(m_t m, bit r, bit v, bit s, int e,
                                int dc, int sc, int unsigned cmax,
                                bit rsel);
        m_t n = m;
        n.done = 0;
        if (r) begin
            n.busy = 0; n.sel = rsel; n.cur = rsel;
            n.en = 1; n.cnt = 0;
        end else if (m.busy) begin
            if (e == m.sel_e) n.sel = m.pend;
            if (e == m.end_e) begin
                n.en = 1; n.cur = m.pend; n.done = 1; n.busy = 0;
                n.cnt = (m.cnt == cmax) ? m.cnt : m.cnt + 1;
            end
        end else if (v) begin
            if (s == m.cur) begin
                n.done = 1;
            end else begin
                n.busy = 1; n.en = 0; n.pend = s;
                n.sel_e = e + dc; n.end_e = e + dc + sc;
            end
        end
        return n;
    endfunction

    function automatic logic [31:0] pack(m_t m);
        return {18'd0, !m.busy, m.done, m.busy, m.sel, m.en, m.cur,
                8'(m.cnt)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        edge_n++;
        m1 = step(m1, rst, v1, s1, edge_n, 4, 8, 255, 1'b0);
        m2 = step(m2, rst, v2, s2, edge_n, 1, 1, 3, 1'b1);
        live = 1;
    end

    always @(negedge clk) begin
        if (live) begin
            chk("model_dut1",
                {18'd0, r1, d1, b1, cs1, ce1, cu1, n1}, pack(m1));
            chk("model_dut2",
                {18'd0, r2, d2, b2, cs2, ce2, cu2, 6'd0, n2}, pack(m2));
        end
    end

    initial begin
        bit got;
        bit saw_done;
        logic [1:0] exp6 [5];
        exp6 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sel", cs1, 0);
        chk("rst_en", ce1, 1);
        chk("rst_ready", r1, 1);
        chk("rst_count", n1, 0);
        rst = 0;
        @(negedge clk);

        // Same-select request: immediate done, no gating
        v1 = 1; s1 = 0;
        @(negedge clk);
        chk("same_done", d1, 1);
        chk("same_en", ce1, 1);
        chk("same_count", n1, 0);
        chk("same_ready", r1, 1);
        v1 = 0;
        @(negedge clk);
        chk("same_done_drop", d1, 0);

        // 0->1 switch with sel=0 held during busy, then back-to-back
        v1 = 1; s1 = 1;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            case (k)
                1: begin
                    chk("sw_en_low", ce1, 0);
                    chk("sw_ready_low", r1, 0);
                    s1 = 0;
                end
                4:  chk("sw_sel_before", cs1, 0);
                5:  chk("sw_sel_flip", cs1, 1);
                12: chk("sw_t12", {ce1, d1, r1}, 3'b000);
                13: begin
                    chk("sw_t13", {ce1, d1, cu1, r1}, 4'b1111);
                    chk("sw_t13_cnt", n1, 1);
                end
                14: begin
                    chk("b2b_t14", {ce1, d1, r1}, 3'b000);
                    v1 = 0;
                end
                17: chk("b2b_sel_before", cs1, 1);
                18: chk("b2b_sel_flip", cs1, 0);
                25: chk("b2b_t25", {ce1, d1}, 2'b00);
                26: begin
                    chk("b2b_t26", {ce1, d1, cu1}, 3'b110);
                    chk("b2b_cnt", n1, 2);
                end
                default: ;
            endcase
        end

        // Reset in the middle of a switch
        v1 = 1; s1 = 1;
        saw_done = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k >= 8 && d1) saw_done = 1;
            case (k)
                1: v1 = 0;
                7: begin
                    chk("abort_pre", {cs1, ce1}, 2'b10);
                    rst = 1;
                end
                8: begin
                    chk("abort_post", {cs1, ce1, r1, d1}, 4'b0110);
                    chk("abort_cnt", n1, 0);
                    rst = 0;
                end
                default: ;
            endcase
        end
        chk("abort_no_done", saw_done, 0);

        // Saturating counter on the narrow instance
        for (int i = 0; i < 5; i++) begin
            s2 = (i % 2 == 0) ? 1'b0 : 1'b1;
            v2 = 1;
            @(negedge clk);
            v2 = 0;
            got = 0;
            for (int c = 0; c < 10 && !got; c++) begin
                if (d2) got = 1;
                else @(negedge clk);
            end
            chk("sat_done_seen", got, 1);
            chk("sat_count", n2, exp6[i]);
        end

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            v1 = ($urandom_range(0, 3) != 0);
            s1 = 1'($urandom_range(0, 1));
            v2 = ($urandom_range(0, 2) != 0);
            s2 = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        rst = 0; v1 = 0; v2 = 0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
